cursor_frame_ctrl: RTL
======================

Name: cursor_frame_ctrl

Overview:
- Receives 32-bit cursor-position words over the SPI link (sck/sdi) from the microcontroller.
- Frames, validates and clamps each word, then commits the position to the video generator only at the start of vertical sync, so the cursor never tears mid-frame.
- Replaces the free-running receive-only shift register in the video path. Runs entirely in the vgaclk domain; sck and sdi are oversampled.

Parameters:
- XMAX, 640, horizontal visible width; committed x is limited to XMAX-1.
- YMAX, 480, vertical visible height; committed y is limited to YMAX-1.
- TIMEOUT, 1024, number of vgaclk cycles without an sck rising edge that aborts a partial word.
- MAXSTEP, 16, per-frame movement limit per axis (used only with CURSOR_SLEW_EN).

Ports:
- vgaclk  input  1  pixel clock, 25.175 MHz.
- reset_b  input  1  asynchronous, active-low reset.
- sck  input  1  SPI clock from master, asynchronous to vgaclk.
- sdi  input  1  SPI data from master, MSB first, asynchronous.
- vsync  input  1  active-low vertical sync from the VGA timing controller.
- xpos  output  10  committed cursor x.
- ypos  output  10  committed cursor y.
- pending  output  1  a validated word is waiting for commit.
- word_err  output  1  one-cycle pulse when a word is rejected or times out.

Behaviour:
- One clock (vgaclk); reset is asynchronous and active-low (reset_b). All flops clear immediately on reset_b=0.
- Reset values: xpos=0, ypos=0, pending=0, word_err=0, FSM=IDLE, bit count=0, timeout counter=0.
- Input conditioning:
  - sck, sdi and vsync each pass through a 2-flop synchronizer.
  - sck rising edge = synchronized sck is 1 and was 0 the previous cycle.
  - sdi is sampled on that edge.
  - Edge-to-shift latency is 3 vgaclk cycles.
- FSM states:
  - IDLE: first sck edge shifts in bit 31, sets bit count to 1, moves to SHIFT.
  - SHIFT: each edge shifts left and increments the count. The timeout counter resets on every edge and increments otherwise. When the 32nd bit is shifted, move to CHECK. If the timeout counter reaches TIMEOUT, discard the partial word, pulse word_err and return to IDLE.
  - CHECK (1 cycle): the word is x = w[25:16], y = w[9:0]. If w[31:26] or w[15:10] is nonzero, pulse word_err and discard. Otherwise clamp x to min(x, XMAX-1) and y to min(y, YMAX-1), load the pending register and set pending=1. Return to IDLE.
- Commit:
  - Triggered on the synchronized vsync falling edge (start of sync pulse).
  - If pending=1, load xpos/ypos from the pending register and clear pending on the next cycle.
  - If pending=0, xpos/ypos hold.
- Latest word wins: a new valid word arriving while pending=1 overwrites the pending register; the older word is never displayed.
- Simultaneous events: if CHECK accepts a word in the same cycle as the vsync falling edge, the new word bypasses the pending register and is committed; pending stays 0.
- Rejected words never disturb the pending register or xpos/ypos.
- Reset mid-word: the partial word is lost and no word_err is issued.
- sck edges arriving while in CHECK are a protocol violation. The edge is dropped and the next edge starts a new word.
- Arithmetic: all comparisons are unsigned 10-bit. Slew arithmetic uses 11-bit signed differences.

Optional Feature:
- Macro: CURSOR_SLEW_EN.
- Defined: at each commit, each axis moves toward the pending target by at most MAXSTEP pixels. pending clears only when both axes equal the target; otherwise it stays 1 and motion continues on the next vsync.
- Undefined: commit jumps directly to the target and the slew logic is absent.

Test Plan:
- Reset, then send 0x0140_00F0 (x=320, y=240), then a vsync falling edge -> pending=1 after CHECK; xpos=320, ypos=240 within 4 cycles of the edge; pending=0.
- Send x=700, y=500 -> committed xpos=639, ypos=479; no word_err.
- Send 0x8000_0010 (reserved bit set) -> word_err pulses for 1 cycle; xpos/ypos and pending unchanged.
- Send 20 bits, then idle for 1100 cycles, then a valid word (x=5, y=6) -> one word_err at timeout; after vsync, xpos=5, ypos=6.
- Send two valid words before one vsync ((10,10) then (20,30)) -> committed (20,30). A word completing on the vsync edge cycle commits that same frame.
- With CURSOR_SLEW_EN, from (0,0) send target (40,8) -> successive vsyncs give (16,8), (32,8), (40,8); pending=0 after the third.

Source files
------------

// File: rtl/cursor_frame_ctrl_if.sv
// Signal bundle between the SPI/VGA-timing side and cursor_frame_ctrl.
// master = MCU and timing side; slave = the cursor frame controller.
interface cursor_frame_ctrl_if;
    logic       sck;
    logic       sdi;
    logic       vsync;
    logic [9:0] xpos;
    logic [9:0] ypos;
    logic       pending;
    logic       word_err;

    modport master (
        output sck, sdi, vsync,
        input  xpos, ypos, pending, word_err
    );

    modport slave (
        input  sck, sdi, vsync,
        output xpos, ypos, pending, word_err
    );
endinterface

// File: rtl/cursor_frame_ctrl.sv
// Oversampled SPI cursor-word receiver. It validates and clamps each word, then commits it at vsync start.
// Optional macro CURSOR_SLEW_EN limits the cursor to MAXSTEP pixels of movement per axis on each commit.
module cursor_frame_ctrl #(
    parameter int XMAX    = 640,
    parameter int YMAX    = 480,
    parameter int TIMEOUT = 1024,
    parameter int MAXSTEP = 16
) (
    input logic                vgaclk,
    input logic                reset_b,
    cursor_frame_ctrl_if.slave bus
);
    localparam int              TW   = $clog2(TIMEOUT + 1);
    localparam logic [9:0]      XLIM = 10'(XMAX - 1);
    localparam logic [9:0]      YLIM = 10'(YMAX - 1);
    localparam logic [TW-1:0]   TLIM = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;

    state_t        r_state;
    logic          r_sck_s1, r_sck_s2, r_sck_d;
    logic          r_sdi_s1, r_sdi_s2;
    logic          r_vs_s1, r_vs_s2, r_vs_d;
    logic [31:0]   r_shift;
    logic [5:0]    r_bits;
    logic [TW-1:0] r_tmo;
    logic [9:0]    r_px, r_py;
    logic [9:0]    r_xpos, r_ypos;
    logic          r_pending;
    logic          r_word_err;

    logic          w_sck_rise, w_vs_fall, w_accept, w_commit;
    logic [9:0]    w_cx, w_cy, w_tx, w_ty, w_nx, w_ny;

    // NOTE: every flop, synchronizers included, sits in the async reset branch; nothing depends on power-up state.
    always_ff @(posedge vgaclk or negedge reset_b) begin
        if (!reset_b) begin
            r_sck_s1 <= 1'b0;
            r_sck_s2 <= 1'b0;
            r_sck_d  <= 1'b0;
            r_sdi_s1 <= 1'b0;
            r_sdi_s2 <= 1'b0;
            r_vs_s1  <= 1'b0;
            r_vs_s2  <= 1'b0;
            r_vs_d   <= 1'b0;
        end else begin
            r_sck_s1 <= bus.sck;
            r_sck_s2 <= r_sck_s1;
            r_sck_d  <= r_sck_s2;
            r_sdi_s1 <= bus.sdi;
            r_sdi_s2 <= r_sdi_s1;
            r_vs_s1  <= bus.vsync;
            r_vs_s2  <= r_vs_s1;
            r_vs_d   <= r_vs_s2;
        end
    end

    assign w_sck_rise = r_sck_s2 & ~r_sck_d;
    assign w_vs_fall  = ~r_vs_s2 & r_vs_d;

    assign w_accept = (r_state == CHECK) && (r_shift[31:26] == 6'd0) && (r_shift[15:10] == 6'd0);
    assign w_cx     = (r_shift[25:16] > XLIM) ? XLIM : r_shift[25:16];
    assign w_cy     = (r_shift[9:0]   > YLIM) ? YLIM : r_shift[9:0];

    // A word accepted on the vsync-edge cycle bypasses the pending register.
    assign w_tx     = w_accept ? w_cx : r_px;
    assign w_ty     = w_accept ? w_cy : r_py;
    assign w_commit = w_vs_fall && (w_accept || r_pending);

`ifdef CURSOR_SLEW_EN
    localparam logic signed [10:0] STEP = 11'(MAXSTEP);

    function automatic logic [9:0] slew_to(input logic [9:0] cur, input logic [9:0] tgt);
        logic signed [10:0] diff;
        diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
        if (diff > STEP)       return cur + STEP[9:0];
        else if (diff < -STEP) return cur - STEP[9:0];
        else                   return tgt;
    endfunction

    assign w_nx = slew_to(r_xpos, w_tx);
    assign w_ny = slew_to(r_ypos, w_ty);
`else
    assign w_nx = w_tx;
    assign w_ny = w_ty;
`endif

    always_ff @(posedge vgaclk or negedge reset_b) begin
        if (!reset_b) begin
            r_state    <= IDLE;
            r_shift    <= 32'd0;
            r_bits     <= 6'd0;
            r_tmo      <= '0;
            r_px       <= 10'd0;
            r_py       <= 10'd0;
            r_xpos     <= 10'd0;
            r_ypos     <= 10'd0;
            r_pending  <= 1'b0;
            r_word_err <= 1'b0;
        end else begin
            r_word_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_sck_rise) begin
                        r_shift <= {31'd0, r_sdi_s2};
                        r_bits  <= 6'd1;
                        r_tmo   <= '0;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (w_sck_rise) begin
                        r_shift <= {r_shift[30:0], r_sdi_s2};
                        r_bits  <= r_bits + 6'd1;
                        r_tmo   <= '0;
                        if (r_bits == 6'd31) r_state <= CHECK;
                    end else if (r_tmo == TLIM) begin
                        r_word_err <= 1'b1;
                        r_bits     <= 6'd0;
                        r_tmo      <= '0;
                        r_state    <= IDLE;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                CHECK: begin
                    // An sck edge landing here is dropped; the next edge starts a fresh word.
                    r_word_err <= ~w_accept;
                    r_bits     <= 6'd0;
                    r_state    <= IDLE;
                end
                default: r_state <= IDLE;
            endcase

            if (w_commit) begin
                r_xpos <= w_nx;
                r_ypos <= w_ny;
`ifdef CURSOR_SLEW_EN
                r_px      <= w_tx;
                r_py      <= w_ty;
                r_pending <= (w_nx != w_tx) || (w_ny != w_ty);
`else
                r_pending <= 1'b0;
`endif
            end else if (w_accept) begin
                r_px      <= w_cx;
                r_py      <= w_cy;
                r_pending <= 1'b1;
            end
        end
    end

    assign bus.xpos     = r_xpos;
    assign bus.ypos     = r_ypos;
    assign bus.pending  = r_pending;
    assign bus.word_err = r_word_err;
endmodule
